// File: rtl/axi_mem_loader.sv
// ---------------------------------------------------------------------------
// axi_mem_loader
//
// AXI4-Lite write-only slave in front of the unified memory's AXI-side write
// port. It accepts one single-beat write at a time and turns each good
// transaction into a one-cycle axi_mem_w strobe. The strobe comes with an
// address and data word that are held until the next good write. It answers
// every transaction with a B response. Misaligned, partial-strobe and
// out-of-range writes are answered with an error and never reach memory.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   s_awaddr/valid/ready  AXI write-address channel
//   s_wdata/wstrb/valid/ready  AXI write-data channel
//   s_bresp/bvalid/bready AXI write-response channel (OKAY/SLVERR/DECERR)
//   axi_mem_w           one-cycle memory write strobe
//   axi_mem_addr        memory byte address of the written word
//   axi_mem_data        memory write data
//   wr_count            saturating count of committed OKAY writes
// ---------------------------------------------------------------------------
module axi_mem_loader #(
    parameter int ADDR_W    = 32,
    parameter int MEM_BYTES = 256,
    localparam int MA_W     = $clog2(MEM_BYTES)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] s_awaddr,
    input  logic              s_awvalid,
    output logic              s_awready,
    input  logic [31:0]       s_wdata,
    input  logic [3:0]        s_wstrb,
    input  logic              s_wvalid,
    output logic              s_wready,
    output logic [1:0]        s_bresp,
    output logic              s_bvalid,
    input  logic              s_bready,
    output logic              axi_mem_w,
    output logic [MA_W-1:0]   axi_mem_addr,
    output logic [31:0]       axi_mem_data,
    output logic [15:0]       wr_count
);

    typedef enum logic [1:0] {
        COLLECT,
        COMMIT,
        RESP
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Highest byte address at which a full 4-byte word still fits in memory.
    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(MEM_BYTES - 4);

    state_t            state;
    state_t            state_next;
    logic              aw_held;
    logic              w_held;
    logic [ADDR_W-1:0] awaddr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        wstrb_q;
    logic [1:0]        bresp_q;

    logic              aw_fire;
    logic              w_fire;
    logic [ADDR_W-1:0] addr_n;
    logic [31:0]       data_n;
    logic [3:0]        strb_n;
    logic              both_ready;
    logic              commit_go;
    logic [1:0]        resp_n;

    // Readies come straight from registered state so that they never depend
    // on the master's valids in the same cycle.
    assign s_awready = (state == COLLECT) && !aw_held;
    assign s_wready  = (state == COLLECT) && !w_held;
    assign s_bvalid  = (state == RESP);
    assign s_bresp   = bresp_q;

    assign aw_fire = s_awvalid && s_awready;
    assign w_fire  = s_wvalid && s_wready;

    // The transaction seen at the moment it becomes complete. The second
    // channel may arrive in the same cycle, so it is taken from the bus
    // rather than from the holding registers.
    assign addr_n     = aw_fire ? s_awaddr : awaddr_q;
    assign data_n     = w_fire  ? s_wdata  : wdata_q;
    assign strb_n     = w_fire  ? s_wstrb  : wstrb_q;
    assign both_ready = (aw_held || aw_fire) && (w_held || w_fire);
    assign commit_go  = (state == COLLECT) && both_ready;

    // Classify the completed transaction. Range errors take priority over
    // alignment/strobe errors. The memory port only writes whole words, so
    // anything other than an aligned full-strobe write is a slave error.
    always_comb begin
        resp_n = RESP_OKAY;
        if (addr_n > LAST_WORD) begin
            resp_n = RESP_DECERR;
        end else if ((addr_n[1:0] != 2'b00) || (strb_n != 4'hF)) begin
            resp_n = RESP_SLVERR;
        end
    end

    // Next-state logic: collect both channels, spend one cycle committing,
    // then wait in RESP for the master to take the response.
    always_comb begin
        state_next = state;
        case (state)
            COLLECT: if (both_ready) state_next = COMMIT;
            COMMIT:  state_next = RESP;
            RESP:    if (s_bready) state_next = COLLECT;
            default: state_next = COLLECT;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= COLLECT;
        end else begin
            state <= state_next;
        end
    end

    // Channel holding registers. Each channel is latched on its own handshake
    // and both are released together when the response is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            awaddr_q <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
        end else begin
            if (aw_fire) begin
                aw_held  <= 1'b1;
                awaddr_q <= s_awaddr;
            end
            if (w_fire) begin
                w_held  <= 1'b1;
                wdata_q <= s_wdata;
                wstrb_q <= s_wstrb;
            end
            if ((state == RESP) && s_bready) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
            end
        end
    end

    // Commit path. The response code and the memory outputs are loaded on
    // the edge that enters COMMIT, so the strobe is high exactly for the
    // COMMIT cycle with its address/data already valid. The strobe is
    // cleared on every other edge, and it drops at once on reset. Error
    // writes leave the memory outputs and the counter untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bresp_q      <= RESP_OKAY;
            axi_mem_w    <= 1'b0;
            axi_mem_addr <= '0;
            axi_mem_data <= '0;
            wr_count     <= '0;
        end else begin
            axi_mem_w <= 1'b0;
            if (commit_go) begin
                bresp_q <= resp_n;
                if (resp_n == RESP_OKAY) begin
                    axi_mem_w    <= 1'b1;
                    axi_mem_addr <= addr_n[MA_W-1:0];
                    axi_mem_data <= data_n;
                    if (wr_count != 16'hFFFF) begin
                        wr_count <= wr_count + 16'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_axi_mem_loader.sv
// ---------------------------------------------------------------------------
// tb_axi_mem_loader
//
// Directed bench for axi_mem_loader. Each transaction pushes its expected
// memory write and B response onto scoreboard queues. A negedge monitor pops
// them when the DUT strobes memory or completes a B handshake. Cycle-level
// checks on readies, strobe timing, counter and held outputs are made inline.
// ---------------------------------------------------------------------------
module tb_axi_mem_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] s_awaddr;
    logic        s_awvalid;
    logic        s_awready;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_wvalid;
    logic        s_wready;
    logic [1:0]  s_bresp;
    logic        s_bvalid;
    logic        s_bready;
    logic        axi_mem_w;
    logic [7:0]  axi_mem_addr;
    logic [31:0] axi_mem_data;
    logic [15:0] wr_count;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [7:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t         expWrQ[$];
    logic [1:0]  expRespQ[$];
    wr_t         monWr;
    logic [1:0]  monResp;
    logic [15:0] expCount;
    logic [7:0]  lastAddr;
    logic [31:0] lastData;

    axi_mem_loader #(
        .ADDR_W    (32),
        .MEM_BYTES (256)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_awaddr     (s_awaddr),
        .s_awvalid    (s_awvalid),
        .s_awready    (s_awready),
        .s_wdata      (s_wdata),
        .s_wstrb      (s_wstrb),
        .s_wvalid     (s_wvalid),
        .s_wready     (s_wready),
        .s_bresp      (s_bresp),
        .s_bvalid     (s_bvalid),
        .s_bready     (s_bready),
        .axi_mem_w    (axi_mem_w),
        .axi_mem_addr (axi_mem_addr),
        .axi_mem_data (axi_mem_data),
        .wr_count     (wr_count)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    // Hard stop in case the design wedges somewhere the bounded waits miss.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] simulation watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: every memory strobe and every B handshake must
    // match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (axi_mem_w) begin
                if (expWrQ.size() == 0) begin
                    checkOutput("unexpected_mem_w", 32'd1, 32'd0);
                end else begin
                    monWr = expWrQ.pop_front();
                    checkOutput("mem_addr", {24'd0, axi_mem_addr}, {24'd0, monWr.a});
                    checkOutput("mem_data", axi_mem_data, monWr.d);
                end
            end
            if (s_bvalid && s_bready) begin
                if (expRespQ.size() == 0) begin
                    checkOutput("unexpected_bresp", 32'd1, 32'd0);
                end else begin
                    monResp = expRespQ.pop_front();
                    checkOutput("bresp", {30'd0, s_bresp}, {30'd0, monResp});
                end
            end
        end
    end

    // Assert reset, check every output immediately, then release it.
    task automatic resetAndCheck();
        rst_n = 1'b0;
        #1;
        checkOutput("rst_awready", {31'd0, s_awready}, 32'd1);
        checkOutput("rst_wready", {31'd0, s_wready}, 32'd1);
        checkOutput("rst_bvalid", {31'd0, s_bvalid}, 32'd0);
        checkOutput("rst_bresp", {30'd0, s_bresp}, 32'd0);
        checkOutput("rst_mem_w", {31'd0, axi_mem_w}, 32'd0);
        checkOutput("rst_mem_addr", {24'd0, axi_mem_addr}, 32'd0);
        checkOutput("rst_mem_data", axi_mem_data, 32'd0);
        checkOutput("rst_wr_count", {16'd0, wr_count}, 32'd0);
        expCount = 16'd0;
        lastAddr = 8'd0;
        lastData = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // One write transaction. wLead > 0 sends W that many cycles ahead of AW.
    // bDelay stalls s_bready. resetAt = 1 resets during COMMIT, 2 during RESP.
    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data,
                                 input logic [3:0] strb, input int wLead,
                                 input int bDelay, input int resetAt);
        logic [1:0] er;
        logic       okay;
        int         n;
        if (addr > 32'd252) er = 2'b11;
        else if ((addr[1:0] != 2'b00) || (strb != 4'hF)) er = 2'b10;
        else er = 2'b00;
        okay = (er == 2'b00);
        if (okay) begin
            expWrQ.push_back({addr[7:0], data});
            if (expCount != 16'hFFFF) expCount = expCount + 16'd1;
            lastAddr = addr[7:0];
            lastData = data;
        end
        expRespQ.push_back(er);
        s_bready = 1'b0;

        if (wLead > 0) begin
            s_wdata  = data;
            s_wstrb  = strb;
            s_wvalid = 1'b1;
            n = 0;
            while (!s_wready && n < 20) begin @(posedge clk); #1; n++; end
            if (n >= 20) checkOutput("wready_timeout", 32'd1, 32'd0);
            @(posedge clk);
            #1;
            s_wvalid = 1'b0;
            checkOutput("wready_low_after_w", {31'd0, s_wready}, 32'd0);
            checkOutput("no_mem_w_before_aw", {31'd0, axi_mem_w}, 32'd0);
            repeat (wLead - 1) begin
                @(posedge clk);
                #1;
                checkOutput("wready_stays_low", {31'd0, s_wready}, 32'd0);
            end
            s_awaddr  = addr;
            s_awvalid = 1'b1;
            n = 0;
            while (!s_awready && n < 20) begin @(posedge clk); #1; n++; end
            if (n >= 20) checkOutput("awready_timeout", 32'd1, 32'd0);
            @(posedge clk);
            #1;
            s_awvalid = 1'b0;
        end else begin
            s_awaddr  = addr;
            s_awvalid = 1'b1;
            s_wdata   = data;
            s_wstrb   = strb;
            s_wvalid  = 1'b1;
            n = 0;
            while (!(s_awready && s_wready) && n < 20) begin @(posedge clk); #1; n++; end
            if (n >= 20) checkOutput("ready_timeout", 32'd1, 32'd0);
            @(posedge clk);
            #1;
            s_awvalid = 1'b0;
            s_wvalid  = 1'b0;
        end

        // One cycle after the last handshake: COMMIT.
        checkOutput("mem_w_commit", {31'd0, axi_mem_w}, {31'd0, okay});
        checkOutput("bvalid_in_commit", {31'd0, s_bvalid}, 32'd0);
        checkOutput("awready_in_commit", {31'd0, s_awready}, 32'd0);
        checkOutput("wready_in_commit", {31'd0, s_wready}, 32'd0);
        if (resetAt == 1) begin
            if (okay) void'(expWrQ.pop_back());
            void'(expRespQ.pop_back());
            #1;
            resetAndCheck();
            return;
        end

        // Two cycles after the last handshake: RESP.
        @(posedge clk);
        #1;
        checkOutput("mem_w_single_pulse", {31'd0, axi_mem_w}, 32'd0);
        checkOutput("bvalid_rise", {31'd0, s_bvalid}, 32'd1);
        checkOutput("bresp_value", {30'd0, s_bresp}, {30'd0, er});
        checkOutput("wr_count", {16'd0, wr_count}, {16'd0, expCount});
        repeat (bDelay) begin
            @(posedge clk);
            #1;
            checkOutput("bvalid_hold", {31'd0, s_bvalid}, 32'd1);
            checkOutput("bresp_stable", {30'd0, s_bresp}, {30'd0, er});
            checkOutput("awready_stall", {31'd0, s_awready}, 32'd0);
            checkOutput("wready_stall", {31'd0, s_wready}, 32'd0);
            checkOutput("mem_w_no_repeat", {31'd0, axi_mem_w}, 32'd0);
        end
        if (resetAt == 2) begin
            void'(expRespQ.pop_back());
            resetAndCheck();
            return;
        end

        s_bready = 1'b1;
        @(posedge clk);
        #1;
        s_bready = 1'b0;
        checkOutput("bvalid_drop", {31'd0, s_bvalid}, 32'd0);
        checkOutput("awready_back", {31'd0, s_awready}, 32'd1);
        checkOutput("wready_back", {31'd0, s_wready}, 32'd1);
        checkOutput("mem_addr_held", {24'd0, axi_mem_addr}, {24'd0, lastAddr});
        checkOutput("mem_data_held", axi_mem_data, lastData);
    endtask

    initial begin
        rst_n     = 1'b1;
        s_awaddr  = '0;
        s_awvalid = 1'b0;
        s_wdata   = '0;
        s_wstrb   = '0;
        s_wvalid  = 1'b0;
        s_bready  = 1'b0;
        expCount  = 16'd0;
        lastAddr  = 8'd0;
        lastData  = 32'd0;
        #3;
        resetAndCheck();

        $display("[TB] same-cycle OKAY write");
        applyStimulus(32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0);
        $display("[TB] W three cycles ahead of AW");
        applyStimulus(32'h20, 32'h11223344, 4'hF, 3, 0, 0);
        $display("[TB] out-of-range writes");
        applyStimulus(32'hFD, 32'h55555555, 4'hF, 0, 0, 0);
        applyStimulus(32'h100, 32'h66666666, 4'hF, 0, 0, 0);
        applyStimulus(32'h1000_0010, 32'h77777777, 4'hF, 0, 0, 0);
        $display("[TB] misaligned and partial-strobe writes");
        applyStimulus(32'h02, 32'h88888888, 4'hF, 0, 0, 0);
        applyStimulus(32'h04, 32'h99999999, 4'h3, 1, 0, 0);
        $display("[TB] last word in memory");
        applyStimulus(32'hFC, 32'hCAFEF00D, 4'hF, 0, 0, 0);
        $display("[TB] response stalled ten cycles");
        applyStimulus(32'h40, 32'h01020304, 4'hF, 0, 10, 0);
        applyStimulus(32'h44, 32'hA5A55A5A, 4'hF, 1, 0, 0);
        $display("[TB] reset during RESP with five writes counted");
        applyStimulus(32'h49, 32'h0BADF00D, 4'hF, 0, 2, 2);
        applyStimulus(32'h80, 32'h13572468, 4'hF, 0, 0, 0);
        $display("[TB] reset during COMMIT");
        applyStimulus(32'h84, 32'hFEEDFACE, 4'hF, 0, 0, 1);
        applyStimulus(32'h88, 32'h24681357, 4'hF, 2, 0, 0);

        repeat (2) @(posedge clk);
        #1;
        checkOutput("sb_writes_drained", expWrQ.size(), 32'd0);
        checkOutput("sb_resps_drained", expRespQ.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
